div_unit: RTL and testbench

Multicycle restoring divider for the DIV/DIVU instructions of the multicycle MIPS core. It is launched by the control FSM and iterates one quotient bit per clock. It presents the registered quotient (LO) and remainder (HI), which feed the HI/LO write-data one-hot 2:1 selector directly downstream. It holds those results stable until the next launch.

---
 rtl/div_pkg.sv | 16 +
 rtl/div_step.sv | 23 ++
 rtl/div_unit.sv | 118 +++++++++++
 tb/tb_div_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the multicycle restoring divider.
package div_pkg;

  localparam int DIV_DATA_WIDTH = 32;

  // Every quotient bit takes this value on a divide by zero.
  localparam logic DIV0_QUOT_FILL = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit and trial-subtract.
module div_step
  import div_pkg::*;
#(
  parameter int DATA_WIDTH = DIV_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] rem_in,
  input  logic                  dvd_bit,
  input  logic [DATA_WIDTH-1:0] dvs_abs,
  output logic [DATA_WIDTH-1:0] rem_out,
  output logic                  q_bit
);

  logic [DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0] trial;

  // rem_in < dvs_abs always holds, so the difference fits in DATA_WIDTH+1 signed bits.
  assign shifted = {rem_in, dvd_bit};
  assign trial   = shifted - {1'b0, dvs_abs};
  assign q_bit   = ~trial[DATA_WIDTH];
  assign rem_out = q_bit ? trial[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Multicycle DIV/DIVU unit: one quotient bit per clock, sign fix-up, results held until next launch.
module div_unit
  import div_pkg::*;
#(
  parameter int DATA_WIDTH = DIV_DATA_WIDTH,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  is_signed,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero
);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

  div_state_t state, state_nxt;
  logic [CNT_WIDTH-1:0] count;

  logic                         op_signed;
  logic signed [DATA_WIDTH-1:0] dvd_orig;
  logic signed [DATA_WIDTH-1:0] dvs_orig;
  logic [DATA_WIDTH-1:0]        dvs_abs;
  logic [DATA_WIDTH-1:0]        work;
  logic [DATA_WIDTH-1:0]        rem;
  logic [DATA_WIDTH-1:0]        step_rem;
  logic                         step_q;
  logic                         neg_q;
  logic                         neg_r;

  function automatic logic [DATA_WIDTH-1:0] cond_neg(input logic [DATA_WIDTH-1:0] v,
                                                     input logic                  neg);
    return neg ? (~v + DATA_WIDTH'(1)) : v;
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (count == LAST_CNT) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy  = (state == RUN) || (state == FIX);
  assign done  = (state == DONE);
  assign neg_q = op_signed & (dvd_orig[DATA_WIDTH-1] ^ dvs_orig[DATA_WIDTH-1]);
  assign neg_r = op_signed & dvd_orig[DATA_WIDTH-1];

  div_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_step (
    .rem_in (rem),
    .dvd_bit(work[DATA_WIDTH-1]),
    .dvs_abs(dvs_abs),
    .rem_out(step_rem),
    .q_bit  (step_q)
  );

  // Control and result registers: reset clears these and abandons any operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: count <= '0;
        RUN:  count <= count + 1'b1;
        FIX: begin
          if (dvs_orig == '0) begin
            quotient    <= {DATA_WIDTH{DIV0_QUOT_FILL}};
            remainder   <= dvd_orig;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= cond_neg(work, neg_q);
            remainder   <= cond_neg(rem, neg_r);
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Operand latch and iteration datapath; work fills with quotient bits as dividend bits leave.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (start) begin
          op_signed <= is_signed;
          dvd_orig  <= dividend;
          dvs_orig  <= divisor;
          work      <= cond_neg(dividend, is_signed & dividend[DATA_WIDTH-1]);
          dvs_abs   <= cond_neg(divisor, is_signed & divisor[DATA_WIDTH-1]);
          rem       <= '0;
        end
      end
      RUN: begin
        rem  <= step_rem;
        work <= {work[DATA_WIDTH-2:0], step_q};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed MIPS cases plus randomized operations against an arithmetic reference.
module tb_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] prev_q = '0;
  logic [31:0] prev_r = '0;
  logic        prev_z = 1'b0;

  div_unit #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .is_signed  (is_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: MIPS DIV/DIVU semantics via 64-bit integer arithmetic (truncating division).
  function automatic void model(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic z);
    longint na, nb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else begin
      if (sgn) begin
        na = longint'($signed(a));
        nb = longint'($signed(b));
      end else begin
        na = longint'({32'd0, a});
        nb = longint'({32'd0, b});
      end
      q = 32'(na / nb);
      r = 32'(na % nb);
      z = 1'b0;
    end
  endfunction

  // Launch at E0, scramble inputs while running, optionally retry start at edge junk_at
  // and in the DONE cycle; both must be ignored.
  task automatic run_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        input int junk_at, input bit junk_done);
    logic [31:0] eq, er;
    logic        ez;
    model(sgn, a, b, eq, er, ez);
    @(negedge clk);
    start = 1'b1; is_signed = sgn; dividend = a; divisor = b;
    @(posedge clk); #1;
    chk("busy_e0", {31'd0, busy}, 32'd1);
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      start     = (k == junk_at);
      is_signed = ~sgn;
      dividend  = $urandom;
      divisor   = $urandom;
      @(posedge clk); #1;
      if (k < 33) begin
        chk("busy_run", {31'd0, busy}, 32'd1);
        chk("done_early", {31'd0, done}, 32'd0);
      end
      if (k == 32) begin
        chk("q_held", quotient, prev_q);
        chk("r_held", remainder, prev_r);
        chk("z_held", {31'd0, div_by_zero}, {31'd0, prev_z});
      end
    end
    chk("done_e33", {31'd0, done}, 32'd1);
    chk("busy_e33", {31'd0, busy}, 32'd0);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("div0", {31'd0, div_by_zero}, {31'd0, ez});
    @(negedge clk);
    start = junk_done;
    @(posedge clk); #1;
    chk("done_e34", {31'd0, done}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    chk("idle_after", {31'd0, busy}, 32'd0);
    chk("q_stable", quotient, eq);
    prev_q = eq;
    prev_r = er;
    prev_z = ez;
  endtask

  initial begin
    int dones;
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_div0", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(1'b0, 32'd100, 32'd7, 0, 1'b0);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b1);
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0, 1'b0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    run_op(1'b1, 32'd5, 32'd0, 0, 1'b0);
    run_op(1'b0, 32'd9, 32'd3, 0, 1'b0);
    run_op(1'b0, 32'd100, 32'd7, 10, 1'b0);
    run_op(1'b0, 32'd5, 32'd0, 0, 1'b1);

    // Reset sampled at E15 of a running operation.
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 15) rst_n = 1'b0;
      @(posedge clk);
    end
    #1;
    chk("mrst_q", quotient, 32'd0);
    chk("mrst_r", remainder, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_done", {31'd0, done}, 32'd0);
    chk("mrst_div0", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("mrst_no_done", 32'(dones), 32'd0);
    prev_q = '0; prev_r = '0; prev_z = 1'b0;

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      bit          sgn;
      int          junk;
      sgn = 1'($urandom);
      a   = $urandom;
      b   = $urandom;
      case ($urandom_range(0, 6))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFF_FFFF;
        3: begin a = 32'h8000_0000; b = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : b; end
        4: a = 32'($urandom_range(0, 20));
        default: ;
      endcase
      junk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 32)) : 0;
      run_op(sgn, a, b, junk, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
